// File: rtl/fetch_stage_if.sv
// Instruction-cache request/response bundle between the fetch stage and the I-cache.
// The fetch stage is the master: it drives the address and request, the cache answers.
interface fetch_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  ic_req;
  logic [DATA_WIDTH-1:0] ic_addr;
  logic                  ic_valid;
  logic [DATA_WIDTH-1:0] ic_data;

  modport master (output ic_req, output ic_addr, input  ic_valid, input  ic_data);
  modport slave  (input  ic_req, input  ic_addr, output ic_valid, output ic_data);
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: PC generation, I-cache miss tracking with redirect-during-miss discard,
// and the F/D pipeline register feeding decode.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  PCSrc_e,
  input  logic [DATA_WIDTH-1:0] PCTarget_e,
  fetch_stage_if.master         ic,
  output logic [DATA_WIDTH-1:0] Instr_d,
  output logic [DATA_WIDTH-1:0] PC_d,
  output logic [DATA_WIDTH-1:0] PCPlus4_d,
  output logic                  Valid_d,
  output logic                  fetch_busy
);

  typedef enum logic [1:0] {
    S_FETCH     = 2'd0,
    S_MISS_WAIT = 2'd1,
    S_DISCARD   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] w_pc_nxt;
  logic [DATA_WIDTH-1:0] r_pend;
  logic [DATA_WIDTH-1:0] w_pend_nxt;
  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic                  w_take;
  logic                  w_fd_load;
  logic                  w_fd_bubble;

  logic [DATA_WIDTH-1:0] r_instr_p1;
  logic [DATA_WIDTH-1:0] r_pc_p1;
  logic [DATA_WIDTH-1:0] r_pcp4_p1;
  logic                  r_vld_p1;

  assign w_pc_plus4 = r_pc + DATA_WIDTH'(4);
  // A fetched word is accepted only when nothing of higher priority intervenes.
  assign w_take     = ic.ic_valid && en && !flush && !PCSrc_e;

  assign ic.ic_req  = !rst;
  assign ic.ic_addr = r_pc;
  assign fetch_busy = (r_state != S_FETCH) || !ic.ic_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_pend;
    w_fd_load   = 1'b0;
    w_fd_bubble = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (PCSrc_e) begin
          w_pc_nxt    = PCTarget_e;
          w_fd_bubble = 1'b1;
        end else if (!ic.ic_valid) begin
          w_state_nxt = S_MISS_WAIT;
          w_fd_bubble = en || flush;
        end else if (w_take) begin
          w_fd_load   = 1'b1;
          w_pc_nxt    = w_pc_plus4;
        end else begin
          w_fd_bubble = flush;
        end
      end
      S_MISS_WAIT: begin
        if (PCSrc_e) begin
          w_fd_bubble = 1'b1;
          if (ic.ic_valid) begin
            w_pc_nxt    = PCTarget_e;
            w_state_nxt = S_FETCH;
          end else begin
            // Keep the PC so the outstanding fill completes; redirect afterwards.
            w_pend_nxt  = PCTarget_e;
            w_state_nxt = S_DISCARD;
          end
        end else if (ic.ic_valid) begin
          w_state_nxt = S_FETCH;
          if (w_take) begin
            w_fd_load = 1'b1;
            w_pc_nxt  = w_pc_plus4;
          end else begin
            w_fd_bubble = flush;
          end
        end else begin
          w_fd_bubble = en || flush;
        end
      end
      S_DISCARD: begin
        if (PCSrc_e) w_pend_nxt = PCTarget_e;
        w_fd_bubble = PCSrc_e || flush || en;
        if (ic.ic_valid) begin
          w_pc_nxt    = PCSrc_e ? PCTarget_e : r_pend;
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // ---- F/D register boundary ----
  always_ff @(posedge clk) begin
    if (rst || w_fd_bubble) begin
      r_instr_p1 <= NOP_INSTR;
      r_pc_p1    <= '0;
      r_pcp4_p1  <= '0;
      r_vld_p1   <= 1'b0;
    end else if (w_fd_load) begin
      r_instr_p1 <= ic.ic_data;
      r_pc_p1    <= r_pc;
      r_pcp4_p1  <= w_pc_plus4;
      r_vld_p1   <= 1'b1;
    end
  end

  assign Instr_d   = r_instr_p1;
  assign PC_d      = r_pc_p1;
  assign PCPlus4_d = r_pcp4_p1;
  assign Valid_d   = r_vld_p1;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of PC, address and instruction.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-003 SHALL have parameter NOP_INSTR, default 32'h0000_0013: instruction inserted as a bubble (addi x0,x0,0).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  1  stall control; low holds PC and the F/D register.
REQ-007 SHALL have port flush  input  1  high forces a bubble into the F/D register.
REQ-008 SHALL have port PCSrc_e  input  1  branch/jump taken in execute; requests a redirect.
REQ-009 SHALL have port PCTarget_e  input  DATA_WIDTH  redirect target address.
REQ-010 SHALL have port ic_req  output  1  instruction-cache request.
REQ-011 SHALL have port ic_addr  output  DATA_WIDTH  instruction-cache address.
REQ-012 SHALL have port ic_valid  input  1  cache data valid (same cycle on hit, later on miss).
REQ-013 SHALL have port ic_data  input  DATA_WIDTH  instruction word from the cache.
REQ-014 SHALL have port Instr_d  output  DATA_WIDTH  registered instruction to decode.
REQ-015 SHALL have port PC_d  output  DATA_WIDTH  registered PC of Instr_d.
REQ-016 SHALL have port PCPlus4_d  output  DATA_WIDTH  registered PC_d+4.
REQ-017 SHALL have port Valid_d  output  1  Instr_d is a real fetched instruction.
REQ-018 SHALL have port fetch_busy  output  1  instruction not available this cycle; hazard unit stalls younger logic.

Function
REQ-019 SHALL hold an internal PC register, a pending-target register, and a 3-state FSM: FETCH, MISS_WAIT, DISCARD.
REQ-020 SHALL drive ic_addr = PC and ic_req = 1 in every non-reset cycle; ic_addr SHALL stay stable from miss until ic_valid.
REQ-021 SHALL drive fetch_busy = (state != FETCH) or not ic_valid, combinationally.
REQ-022 Priority each cycle SHALL be rst > PCSrc_e > flush > en.
REQ-023 FETCH, ic_valid, en, no redirect/flush: F/D <= {ic_data, PC, PC+4, Valid 1}; PC <= PC+4 (modulo 2^DATA_WIDTH wrap); stay FETCH.
REQ-024 FETCH, not ic_valid, no redirect: PC held; if en, F/D <= bubble; go MISS_WAIT.
REQ-025 MISS_WAIT, ic_valid, en, no redirect/flush: capture as REQ-023; go FETCH.
REQ-026 MISS_WAIT, ic_valid, en low: drop data, PC held, go FETCH (line now resident, re-hits next cycle).
REQ-027 en low, no redirect/flush: F/D and PC SHALL hold; FSM transitions per REQ-024/026 still apply.
REQ-028 Bubble SHALL be Instr_d=NOP_INSTR, PC_d=0, PCPlus4_d=0, Valid_d=0.
REQ-029 PCSrc_e in FETCH: PC <= PCTarget_e; F/D <= bubble regardless of en; stay FETCH.
REQ-030 PCSrc_e in MISS_WAIT with ic_valid same cycle: PC <= PCTarget_e, F/D bubble, go FETCH.
REQ-031 PCSrc_e in MISS_WAIT without ic_valid: pending <= PCTarget_e, F/D bubble, go DISCARD; PC held so outstanding fill completes.
REQ-032 DISCARD: each new PCSrc_e overwrites pending; on ic_valid, data dropped, PC <= pending (or PCTarget_e if PCSrc_e same cycle), go FETCH.
REQ-033 flush without PCSrc_e: F/D <= bubble regardless of en; PC and FSM behave as if en low.
REQ-034 Data delivered in DISCARD SHALL never reach Valid_d=1.
REQ-035 Latency: hit SHALL appear on Instr_d one cycle after the address is presented; N-cycle miss SHALL appear N+1 cycles after.

Reset
REQ-036 rst high at a rising edge SHALL set PC=RESET_PC, pending=0, state=FETCH, F/D=bubble; overrides all inputs including mid-miss and DISCARD.
REQ-037 ic_req SHALL be 0 while rst is high; the first request after reset SHALL be at RESET_PC.

Verification
REQ-038 Reset, all hits, en=1 -> ic_addr 0,4,8; Instr_d from cycle 1 with PC_d 0,4,8 and Valid_d=1.
REQ-039 Miss at 0x8 for 3 cycles -> fetch_busy=1 and three bubbles; ic_addr held at 0x8; then Instr_d PC_d=0x8 and Valid_d=1.
REQ-040 Redirect during miss at 0x10 to 0x40 -> DISCARD; fill data for 0x10 never reaches Valid_d=1; next ic_addr=0x40.
REQ-041 en=0 for 2 cycles on hits -> Instr_d/PC_d frozen and ic_addr unchanged; resume at the same PC with no instruction lost or duplicated.
REQ-042 PCSrc_e with en=0 and flush=1 -> F/D bubble and next ic_addr=PCTarget_e.
REQ-043 PC=0xFFFF_FFFC hit -> next PC wraps to 0x0, PCPlus4_d=0x0; rst asserted during MISS_WAIT -> reset values next cycle.
